// File: rtl/packet_read_arbiter.sv
// Round-robin arbiter sharing one stream_from_memory read port among NUM_REQ requesters.
// Define PRA_WATCHDOG_EN to add the stream watchdog (sfm_rst abort pulse and timeout_err).
`ifndef PACKET_BUFFER_SIZE
`define PACKET_BUFFER_SIZE 2048
`endif

module packet_read_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int RAM_SIZE       = `PACKET_BUFFER_SIZE,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int AW            = $clog2(RAM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*AW-1:0] req_start,
    input  logic [NUM_REQ*AW-1:0] req_end,
    output logic [NUM_REQ-1:0]    ack,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  busy,
    input  logic                  downstream_readclk,
    output logic                  sfm_start,
    output logic [AW-1:0]         sfm_read_start,
    output logic [AW-1:0]         sfm_read_end,
    output logic                  sfm_readclk,
    input  logic                  sfm_done,
    output logic                  sfm_rst
`ifdef PRA_WATCHDOG_EN
    ,
    output logic                  timeout_err
`endif
);

    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, LAUNCH, STREAM, GAP} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [AW-1:0]        rd_start_q, rd_start_d;
    logic [AW-1:0]        rd_end_q, rd_end_d;
    logic [PW-1:0]        rr_q, rr_d;
    logic [3:0]           gap_q, gap_d;
    logic [PW-1:0]        sel;
    logic                 found;
    logic [AW-1:0]        sel_start, sel_end;

`ifdef PRA_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          sfm_rst_q, sfm_rst_d;
    logic          err_q, err_d;
`endif

    // Search starts just after the last winner, so it ends up with lowest priority.
    always_comb begin
        found = 1'b0;
        sel   = rr_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req[(int'(rr_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                sel   = PW'((int'(rr_q) + k) % NUM_REQ);
            end
        end
        sel_start = req_start[int'(sel)*AW +: AW];
        sel_end   = req_end[int'(sel)*AW +: AW];
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ack_d      = '0;
        rd_start_d = rd_start_q;
        rd_end_d   = rd_end_q;
        rr_d       = rr_q;
        gap_d      = gap_q;
`ifdef PRA_WATCHDOG_EN
        wd_d       = wd_q;
        sfm_rst_d  = 1'b0;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (found) begin
                    grant_d[sel] = 1'b1;
                    rd_start_d   = sel_start;
                    rd_end_d     = sel_end;
                    rr_d         = sel;
                    if (sel_start == sel_end) begin
                        ack_d[sel] = 1'b1;
                        gap_d      = '0;
                        state_d    = (GAP_CYCLES > 0) ? GAP : IDLE;
                    end else begin
                        state_d = LAUNCH;
`ifdef PRA_WATCHDOG_EN
                        wd_d    = '0;
`endif
                    end
                end
            end
            LAUNCH: begin
                state_d = STREAM;
`ifdef PRA_WATCHDOG_EN
                wd_d    = wd_q + 1'b1;
`endif
            end
            STREAM: begin
                if (sfm_done) begin
                    ack_d   = grant_q;
                    grant_d = '0;
                    gap_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
`ifdef PRA_WATCHDOG_EN
                end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
                    ack_d     = grant_q;
                    grant_d   = '0;
                    gap_d     = '0;
                    sfm_rst_d = 1'b1;
                    err_d     = 1'b1;
                    state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
`endif
                end
            end
            GAP: begin
                grant_d = '0;
                if (gap_q == 4'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ack_q      <= '0;
            rd_start_q <= '0;
            rd_end_q   <= '0;
            rr_q       <= PW'(NUM_REQ - 1);
            gap_q      <= '0;
`ifdef PRA_WATCHDOG_EN
            wd_q       <= '0;
            sfm_rst_q  <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            rd_start_q <= rd_start_d;
            rd_end_q   <= rd_end_d;
            rr_q       <= rr_d;
            gap_q      <= gap_d;
`ifdef PRA_WATCHDOG_EN
            wd_q       <= wd_d;
            sfm_rst_q  <= sfm_rst_d;
            err_q      <= err_d;
`endif
        end
    end

    assign grant          = grant_q;
    assign ack            = ack_q;
    assign busy           = (state_q != IDLE);
    assign sfm_start      = (state_q == LAUNCH);
    assign sfm_read_start = rd_start_q;
    assign sfm_read_end   = rd_end_q;
    // Readclk is only passed through while the stream owns the port.
    assign sfm_readclk    = downstream_readclk & ((state_q == LAUNCH) || (state_q == STREAM));
`ifdef PRA_WATCHDOG_EN
    assign sfm_rst        = sfm_rst_q;
    assign timeout_err    = err_q;
`else
    assign sfm_rst        = 1'b0;
`endif

endmodule

// File: tb/tb_packet_read_arbiter.sv
// Directed bench for packet_read_arbiter (NUM_REQ=2, GAP_CYCLES=2, TIMEOUT_CYCLES=16).
// Watchdog scenario is compiled in when PRA_WATCHDOG_EN is defined.
module tb_packet_read_arbiter;

    localparam int AW = 11;

    logic          clk;
    logic          rst;
    logic [1:0]    req;
    logic [2*AW-1:0] req_start;
    logic [2*AW-1:0] req_end;
    logic [1:0]    ack;
    logic [1:0]    grant;
    logic          busy;
    logic          drl;
    logic          sfm_start;
    logic [AW-1:0] sfm_read_start;
    logic [AW-1:0] sfm_read_end;
    logic          sfm_readclk;
    logic          sfm_done;
    logic          sfm_rst;
`ifdef PRA_WATCHDOG_EN
    logic          timeout_err;
`endif

    int checks = 0;
    int errors = 0;

    packet_read_arbiter #(
        .NUM_REQ(2), .RAM_SIZE(2048), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_start(req_start), .req_end(req_end),
        .ack(ack), .grant(grant), .busy(busy), .downstream_readclk(drl),
        .sfm_start(sfm_start), .sfm_read_start(sfm_read_start), .sfm_read_end(sfm_read_end),
        .sfm_readclk(sfm_readclk), .sfm_done(sfm_done), .sfm_rst(sfm_rst)
`ifdef PRA_WATCHDOG_EN
        , .timeout_err(timeout_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        rst = 1'b1; req = '0; req_start = '0; req_end = '0; drl = 1'b1; sfm_done = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({grant, ack, busy, sfm_start, sfm_readclk, sfm_rst} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs: got grant=%b ack=%b busy=%b start=%b rclk=%b srst=%b, want all 0",
                     grant, ack, busy, sfm_start, sfm_readclk, sfm_rst);
        end
        checks++;
        if (sfm_read_start !== '0 || sfm_read_end !== '0) begin
            errors++;
            $display("FAIL reset_addr: got %h/%h want 000/000", sfm_read_start, sfm_read_end);
        end
`ifdef PRA_WATCHDOG_EN
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_timeout_err: got %b want 0", timeout_err);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b want 0", busy);
        end
    endtask

    task automatic test_single();
        req_start[0 +: AW] = 11'h010; req_end[0 +: AW] = 11'h014; drl = 1'b1; req = 2'b01;
        @(negedge clk);
        checks++;
        if (grant !== 2'b01 || sfm_start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_launch: grant=%b start=%b busy=%b want 01/1/1", grant, sfm_start, busy);
        end
        @(negedge clk);
        checks++;
        if (sfm_start !== 1'b0 || sfm_read_start !== 11'h010 || sfm_read_end !== 11'h014) begin
            errors++;
            $display("FAIL single_stream: start=%b rs=%h re=%h want 0/010/014", sfm_start, sfm_read_start, sfm_read_end);
        end
        sfm_done = 1'b1;
        @(negedge clk);
        sfm_done = 1'b0; req = 2'b00;
        checks++;
        if (ack !== 2'b01 || grant !== 2'b00 || sfm_start !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: ack=%b grant=%b start=%b want 01/00/0", ack, grant, sfm_start);
        end
        @(negedge clk);
        checks++;
        if (ack !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_gap: ack=%b busy=%b want 00/1", ack, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_g [4];
        logic [1:0] prev;
        logic       got;
        exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
        prev = 2'b01;
        req_start[AW +: AW] = 11'h200; req_end[AW +: AW] = 11'h208;
        req = 2'b11;
        for (int p = 0; p < 4; p++) begin
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clk);
                if (grant !== 2'b00) got = 1'b1;
            end
            checks++;
            if (!got || grant !== exp_g[p] || grant === prev) begin
                errors++;
                $display("FAIL contention_grant%0d: got %b want %b (prev %b)", p, grant, exp_g[p], prev);
            end
            prev = grant;
            @(negedge clk);
            sfm_done = 1'b1;
            @(negedge clk);
            sfm_done = 1'b0;
            if (p == 3) req = 2'b00;
            checks++;
            if (ack !== exp_g[p]) begin
                errors++;
                $display("FAIL contention_ack%0d: got %b want %b", p, ack, exp_g[p]);
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL contention_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_empty();
        int bad;
        req_start[AW +: AW] = 11'h100; req_end[AW +: AW] = 11'h100; drl = 1'b1; req = 2'b10;
        @(negedge clk);
        req = 2'b00;
        checks++;
        if (ack !== 2'b10 || sfm_start !== 1'b0 || sfm_readclk !== 1'b0) begin
            errors++;
            $display("FAIL empty_ack: ack=%b start=%b rclk=%b want 10/0/0", ack, sfm_start, sfm_readclk);
        end
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (sfm_start !== 1'b0 || sfm_readclk !== 1'b0 || ack !== 2'b00) bad++;
        end
        checks++;
        if (bad != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_quiet: bad_cycles=%0d busy=%b want 0/0", bad, busy);
        end
    endtask

    task automatic test_readclk();
        int bad;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drl = ~drl; #1;
            if (sfm_readclk !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL readclk_idle: %0d cycles with readclk high, want 0", bad);
        end
        req_start[0 +: AW] = 11'h020; req_end[0 +: AW] = 11'h030; req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        checks++;
        if (grant !== 2'b01) begin
            errors++;
            $display("FAIL readclk_grant: got %b want 01", grant);
        end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            drl = ~drl; #1;
            if (sfm_readclk !== drl) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL readclk_mirror: %0d cycles differ from downstream, want 0", bad);
        end
        sfm_done = 1'b1;
        @(negedge clk);
        sfm_done = 1'b0;
        checks++;
        if (ack !== 2'b01) begin
            errors++;
            $display("FAIL dropped_req_ack: got %b want 01", ack);
        end
        bad = 0;
        for (int c = 0; c < 2; c++) begin
            if (c > 0) @(negedge clk);
            drl = ~drl; #1;
            if (sfm_readclk !== 1'b0) bad++;
            drl = ~drl; #1;
            if (sfm_readclk !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL readclk_gap: %0d samples high, want 0", bad);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int bad;
        req_start[0 +: AW] = 11'h040; req_end[0 +: AW] = 11'h050; drl = 1'b1; req = 2'b01;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || grant !== 2'b01 || sfm_start !== 1'b0) begin
            errors++;
            $display("FAIL midrst_stream: busy=%b grant=%b start=%b want 1/01/0", busy, grant, sfm_start);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (grant !== 2'b00 || busy !== 1'b0 || sfm_start !== 1'b0 || ack !== 2'b00 || sfm_readclk !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: grant=%b busy=%b start=%b ack=%b rclk=%b want all 0",
                     grant, busy, sfm_start, ack, sfm_readclk);
        end
        req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ack !== 2'b00 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midrst_no_ack: %0d cycles with ack/busy, want 0", bad);
        end
        sfm_done = 1'b1;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (ack !== 2'b00 || busy !== 1'b0) bad++;
        end
        sfm_done = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL done_outside_stream: %0d cycles with ack/busy, want 0", bad);
        end
    endtask

`ifdef PRA_WATCHDOG_EN
    task automatic test_watchdog();
        int n;
        logic seen_rst;
        req_start[0 +: AW] = 11'h000; req_end[0 +: AW] = 11'h008; req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        checks++;
        if (grant !== 2'b01 || sfm_start !== 1'b1) begin
            errors++;
            $display("FAIL wd_launch: grant=%b start=%b want 01/1", grant, sfm_start);
        end
        n = 0; seen_rst = 1'b0;
        for (int c = 1; c <= 40 && n == 0; c++) begin
            @(negedge clk);
            if (ack !== 2'b00) begin
                n = c;
                seen_rst = sfm_rst;
            end
        end
        checks++;
        if (n != 16 || seen_rst !== 1'b1 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL wd_timeout: ack after %0d cycles srst=%b err=%b want 16/1/1", n, seen_rst, timeout_err);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1 || sfm_rst !== 1'b0 || ack !== 2'b00) begin
            errors++;
            $display("FAIL wd_sticky: err=%b srst=%b ack=%b want 1/0/00", timeout_err, sfm_rst, ack);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_empty();
        test_readclk();
        test_reset_mid();
`ifdef PRA_WATCHDOG_EN
        test_watchdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
